uart_autobaud_ctrl: RTL and testbench
=====================================

# uart_autobaud_ctrl

Auto-baud controller for the UART receive path. On request, it measures the start bit and first data bit of a host-sent 0x55 sync character on the raw serial line. It classifies the bit period against the four supported rates and drives the 2-bit `baud_rate` select of the `Sampling` baud generator. It then holds that setting until the next request.

## Interface
- `CNT_W`, 16: width of the phase counter; the counter saturates at all-ones.
- `P0`, 20833: bit period in clocks for code 2'b00 (2400 baud at 50 MHz).
- `P1`, 10417: bit period for code 2'b01 (4800).
- `P2`, 5208: bit period for code 2'b10 (9600).
- `P3`, 2604: bit period for code 2'b11 (19200).
- `IDLE_CYCLES`, 2604: consecutive synced-high cycles required before arming.
- `clock`  in  1  system clock (50 MHz); single clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  single-cycle request to begin detection.
- `rx`  in  1  raw asynchronous serial line.
- `baud_rate`  out  2  rate select to `Sampling`. Reset value 2'b10.
- `busy`  out  1  high while detection is in progress. Reset value 0.
- `locked`  out  1  high after a successful detection, until the next `start`. Reset value 0.
- `error`  out  1  high after a failed detection, until the next `start`. Reset value 0.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`. A registered copy `rx_d` provides edge detection: fall = `rx_d & ~rx_s`, rise = `~rx_d & rx_s`.
- States:
  - IDLE: `start` clears `locked`/`error`, sets `busy`, clears the counter, and moves to WAIT_IDLE.
  - WAIT_IDLE: counts cycles with `rx_s`=1. A cycle with `rx_s`=0 resets the count. When the count reaches `IDLE_CYCLES`, moves to WAIT_FALL.
  - WAIT_FALL: on a fall, sets counter=1 and moves to MEAS_LOW.
  - MEAS_LOW: increments the counter while `rx_s`=0. On a rise:
    - If the count < `P3 - (P3>>3)`, it is a glitch: return to WAIT_FALL with no error.
    - Otherwise latch `low_cnt`, set counter=1, and move to MEAS_HIGH.
  - MEAS_HIGH: increments the counter while `rx_s`=1. On a fall, latch `high_cnt` and move to CHECK.
  - CHECK (1 cycle): classify both `low_cnt` and `high_cnt`. A value matches code k when |cnt − Pk| ≤ Pk>>3; the windows are disjoint.
    - If both values match the same k: `baud_rate`←k, `locked`←1.
    - Otherwise: `error`←1 and `baud_rate` unchanged.
    - `busy`←0 and return to IDLE.
- Timeout: if the counter reaches all-ones in MEAS_LOW or MEAS_HIGH, go to IDLE with `error`=1, `busy`=0, and `baud_rate` unchanged.
- `start` while `busy` is ignored. `start` in IDLE with `locked` or `error` set re-arms and clears both.
- Classification arithmetic uses CNT_W+1 bits to avoid underflow. The tolerance is a right-shift by 3 (12.5%).
- `baud_rate` changes only in CHECK. It never glitches mid-detection.

## Timing
- `rx`→`rx_s` latency: 2 cycles. Edges are seen 3 cycles after the `rx` transition, with equal offset on both edges, so measured widths equal the true widths in clocks.
- `busy` rises the cycle after `start` is sampled.
- `locked`/`error` and the new `baud_rate` are registered together in CHECK. They are visible 2 cycles after the terminating fall is detected, the same cycle `busy` falls.
- Synchronous reset at any point, including mid-measurement, returns to IDLE with all outputs at reset values and counters cleared. `baud_rate` returns to 2'b10.
- `start` and `reset_n` low in the same cycle: reset wins.
- `locked` and `error` are never both high.

## Test plan
- Reset then idle: hold `reset_n`=0 for 5 cycles with `rx`=1 → `baud_rate`=2'b10, `busy`=`locked`=`error`=0.
- 0x55 sync frames at 9600 (5208 cycles/bit), then at 2400 (20833 cycles/bit) → `baud_rate`=2'b10 then 2'b00; each run ends with `locked`=1 and `busy`=0, and `baud_rate` stays constant between runs.
- Tolerance: low=2604+325 and high=2604−325 → locked with 2'b11. Low=2604+326 → `error`=1, `baud_rate` unchanged.
- Mismatch: low=5208, high=2604 → `error`=1, `locked`=0, `baud_rate` unchanged.
- Glitch then valid: a 100-cycle low pulse, then a valid 4800 frame (10417/bit) → no error; `baud_rate`=2'b01 and `locked`=1.
- Robustness:
  - Holding `rx` low 70000 cycles after a fall → `error`=1 via timeout.
  - A second `start` while busy → ignored.
  - Asserting `reset_n`=0 mid-MEAS_HIGH → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/uart_autobaud_ctrl_if.sv
// Handshake and status bundle between the host-side controller and the
// auto-baud block: request/serial-line inputs and rate/status outputs.
interface uart_autobaud_ctrl_if;
  logic       start;
  logic       rx;
  logic [1:0] baud_rate;
  logic       busy;
  logic       locked;
  logic       error;

  modport master (
    output start, rx,
    input  baud_rate, busy, locked, error
  );

  modport slave (
    input  start, rx,
    output baud_rate, busy, locked, error
  );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: measures the start bit and first data bit of a 0x55
// sync character on the raw rx line, classifies the bit period against four
// supported rates and holds the resulting rate select until the next request.
module uart_autobaud_ctrl #(
  parameter int CNT_W       = 16,
  parameter int P0          = 20833,
  parameter int P1          = 10417,
  parameter int P2          = 5208,
  parameter int P3          = 2604,
  parameter int IDLE_CYCLES = 2604
) (
  input  logic                  clock,
  input  logic                  reset_n,
  uart_autobaud_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_IDLE = 3'd1;
  localparam logic [2:0] S_WAIT_FALL = 3'd2;
  localparam logic [2:0] S_MEAS_LOW  = 3'd3;
  localparam logic [2:0] S_MEAS_HIGH = 3'd4;
  localparam logic [2:0] S_CHECK     = 3'd5;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GLITCH_MIN = CNT_W'(P3 - (P3 >> 3));

  // Periods widened by one bit so |cnt - P| never underflows.
  localparam logic [CNT_W:0] PER0 = (CNT_W+1)'(P0);
  localparam logic [CNT_W:0] PER1 = (CNT_W+1)'(P1);
  localparam logic [CNT_W:0] PER2 = (CNT_W+1)'(P2);
  localparam logic [CNT_W:0] PER3 = (CNT_W+1)'(P3);

  // True when cnt lies within +/-12.5% of the nominal period per.
  function automatic logic in_window(input logic [CNT_W-1:0] cnt, input logic [CNT_W:0] per);
    logic [CNT_W:0] ext;
    logic [CNT_W:0] diff;
    ext = {1'b0, cnt};
    if (ext >= per) begin
      diff = ext - per;
    end else begin
      diff = per - ext;
    end
    return (diff <= (per >> 3));
  endfunction

  logic             rx_meta;
  logic             rx_s;
  logic             rx_d;
  logic             fall;
  logic             rise;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [1:0]       baud_rate_r;
  logic             busy_r;
  logic             locked_r;
  logic             error_r;
  logic [3:0]       low_hit;
  logic [3:0]       high_hit;
  logic [3:0]       both_hit;
  logic             match;
  logic [1:0]       match_code;

  assign fall = rx_d & ~rx_s;
  assign rise = ~rx_d & rx_s;

  assign bus.baud_rate = baud_rate_r;
  assign bus.busy      = busy_r;
  assign bus.locked    = locked_r;
  assign bus.error     = error_r;

  // Two-flop synchronizer plus one delay stage for edge detection; idles high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  // Classify both measured widths; a lock needs both in the same rate window.
  always_comb begin
    low_hit  = {in_window(low_cnt, PER3), in_window(low_cnt, PER2),
                in_window(low_cnt, PER1), in_window(low_cnt, PER0)};
    high_hit = {in_window(high_cnt, PER3), in_window(high_cnt, PER2),
                in_window(high_cnt, PER1), in_window(high_cnt, PER0)};
    both_hit = low_hit & high_hit;
    match    = |both_hit;
    if (both_hit[3]) begin
      match_code = 2'd3;
    end else if (both_hit[2]) begin
      match_code = 2'd2;
    end else if (both_hit[1]) begin
      match_code = 2'd1;
    end else begin
      match_code = 2'd0;
    end
  end

  // Detection sequencer: idle qualification, low/high measurement, decision.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= CNT_ZERO;
      low_cnt     <= CNT_ZERO;
      high_cnt    <= CNT_ZERO;
      baud_rate_r <= 2'b10;
      busy_r      <= 1'b0;
      locked_r    <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            locked_r <= 1'b0;
            error_r  <= 1'b0;
            busy_r   <= 1'b1;
            cnt      <= CNT_ZERO;
            state    <= S_WAIT_IDLE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) begin
            if (cnt == IDLE_LAST) begin
              cnt   <= CNT_ZERO;
              state <= S_WAIT_FALL;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            cnt <= CNT_ZERO;
          end
        end
        S_WAIT_FALL: begin
          if (fall) begin
            cnt   <= CNT_ONE;
            state <= S_MEAS_LOW;
          end else begin
            state <= S_WAIT_FALL;
          end
        end
        S_MEAS_LOW: begin
          if (rise) begin
            if (cnt < GLITCH_MIN) begin
              // Too short to be a start bit at any supported rate.
              state <= S_WAIT_FALL;
            end else begin
              low_cnt <= cnt;
              cnt     <= CNT_ONE;
              state   <= S_MEAS_HIGH;
            end
          end else if (cnt == CNT_MAX) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= S_IDLE;
          end else if (!rx_s) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt;
          end
        end
        S_MEAS_HIGH: begin
          if (fall) begin
            high_cnt <= cnt;
            state    <= S_CHECK;
          end else if (cnt == CNT_MAX) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state   <= S_IDLE;
          end else if (rx_s) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt;
          end
        end
        S_CHECK: begin
          if (match) begin
            baud_rate_r <= match_code;
            locked_r    <= 1'b1;
          end else begin
            error_r <= 1'b1;
          end
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl. Bit periods are scaled down so that every
// scenario, including the counter-saturation timeout, finishes quickly.
module tb_uart_autobaud_ctrl;

  localparam int CNT_W  = 12;
  localparam int TP0    = 2083;
  localparam int TP1    = 1042;
  localparam int TP2    = 521;
  localparam int TP3    = 260;
  localparam int TIDLE  = 260;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clock;
  logic reset_n;

  uart_autobaud_ctrl_if bus ();

  uart_autobaud_ctrl #(
    .CNT_W(CNT_W), .P0(TP0), .P1(TP1), .P2(TP2), .P3(TP3), .IDLE_CYCLES(TIDLE)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference expectations
  logic [1:0] exp_rate;
  logic       exp_locked;
  logic       exp_error;

  function automatic int period_of(input int k);
    case (k)
      0:       return TP0;
      1:       return TP1;
      2:       return TP2;
      default: return TP3;
    endcase
  endfunction

  // Which rate (0..3) a width belongs to, or -1 if outside every window.
  function automatic int classify_ref(input int w);
    for (int k = 0; k < 4; k++) begin
      int p;
      int d;
      p = period_of(k);
      d = (w > p) ? (w - p) : (p - w);
      if (d <= p / 8) return k;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_rx(input logic level, input int n);
    bus.rx = level;
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_not_busy(input string tag, input int limit);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, {7'd0, bus.busy}, 8'd0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_locked"}, {7'd0, bus.locked}, {7'd0, exp_locked});
    check({tag, "_error"},  {7'd0, bus.error},  {7'd0, exp_error});
    check({tag, "_rate"},   {6'd0, bus.baud_rate}, {6'd0, exp_rate});
    check({tag, "_excl"},   {7'd0, bus.locked & bus.error}, 8'd0);
  endtask

  task automatic begin_det(input string tag);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check({tag, "_busy_rise"}, {7'd0, bus.busy}, 8'd1);
    drive_rx(1'b1, TIDLE + 8);
  endtask

  // Finish the second bit with a fall, then compare against the model.
  task automatic end_det(input string tag, input int low_w, input int high_w);
    int kl;
    int kh;
    bus.rx = 1'b0;
    wait_not_busy(tag, 60);
    kl = classify_ref(low_w);
    kh = classify_ref(high_w);
    if (kl >= 0 && kl == kh) begin
      exp_locked = 1'b1;
      exp_error  = 1'b0;
      exp_rate   = 2'(kl);
    end else begin
      exp_locked = 1'b0;
      exp_error  = 1'b1;
    end
    check_outputs(tag);
    drive_rx(1'b0, 20);
    drive_rx(1'b1, 20);
  endtask

  task automatic run_det(input string tag, input int low_w, input int high_w);
    begin_det(tag);
    drive_rx(1'b0, low_w);
    check({tag, "_rate_hold"}, {6'd0, bus.baud_rate}, {6'd0, exp_rate});
    drive_rx(1'b1, high_w);
    end_det(tag, low_w, high_w);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rx    = 1'b1;
    reset_n   = 1'b0;
    exp_rate   = 2'b10;
    exp_locked = 1'b0;
    exp_error  = 1'b0;
    repeat (5) @(negedge clock);
    check_outputs("reset");
    check("reset_busy", {7'd0, bus.busy}, 8'd0);
    reset_n = 1'b1;
    drive_rx(1'b1, 10);

    // 9600-equivalent frame with a stray start in the middle of the high bit
    begin_det("r9600");
    drive_rx(1'b0, TP2);
    drive_rx(1'b1, TP2 / 2);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    check("r9600_start_ignored", {7'd0, bus.busy}, 8'd1);
    drive_rx(1'b1, TP2 - TP2 / 2 - 1);
    end_det("r9600", TP2, TP2);

    // 2400-equivalent frame
    run_det("r2400", TP0, TP0);
    check("between_runs_rate", {6'd0, bus.baud_rate}, 8'd0);

    // Tolerance edge: both just inside the fastest-rate window
    run_det("tol_in", TP3 + TP3 / 8, TP3 - TP3 / 8);
    // One clock beyond the window
    run_det("tol_out", TP3 + TP3 / 8 + 1, TP3);
    // Widths in different windows
    run_det("mismatch", TP2, TP3);

    // Glitch followed by a valid 4800-equivalent frame
    begin_det("glitch");
    drive_rx(1'b0, 100);
    drive_rx(1'b1, 300);
    check("glitch_no_error", {7'd0, bus.error}, 8'd0);
    check("glitch_still_busy", {7'd0, bus.busy}, 8'd1);
    drive_rx(1'b0, TP1);
    drive_rx(1'b1, TP1);
    end_det("glitch", TP1, TP1);

    // Line held low past counter saturation
    begin_det("timeout");
    bus.rx = 1'b0;
    wait_not_busy("timeout", CNT_SAT + 50);
    exp_locked = 1'b0;
    exp_error  = 1'b1;
    check_outputs("timeout");
    drive_rx(1'b1, 20);

    // Randomised widths around the supported periods
    for (int t = 0; t < 6; t++) begin
      int k;
      int kh;
      int tol;
      int lw;
      int hw;
      k   = int'($urandom_range(0, 3));
      tol = period_of(k) / 8;
      lw  = period_of(k) + int'($urandom_range(0, 2 * tol + 8)) - (tol + 4);
      if (lw < TP3 - TP3 / 8) lw = TP3 - TP3 / 8;
      kh  = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 3)) : k;
      tol = period_of(kh) / 8;
      hw  = period_of(kh) + int'($urandom_range(0, 2 * tol + 8)) - (tol + 4);
      run_det($sformatf("rand%0d", t), lw, hw);
    end

    // Lock to a non-default rate, then reset during the high measurement
    run_det("pre_reset", TP1, TP1);
    begin_det("mid_reset");
    drive_rx(1'b0, TP2);
    drive_rx(1'b1, 200);
    reset_n   = 1'b0;
    bus.start = 1'b1;
    @(negedge clock);
    exp_rate   = 2'b10;
    exp_locked = 1'b0;
    exp_error  = 1'b0;
    check_outputs("mid_reset");
    check("mid_reset_busy", {7'd0, bus.busy}, 8'd0);
    reset_n   = 1'b1;
    bus.start = 1'b0;
    drive_rx(1'b1, 3);
    check("reset_wins_busy", {7'd0, bus.busy}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
